decode_stage: RTL

Instruction-decode pipeline stage between fetch and execute. Drives the register file's two read addresses from the incoming instruction word and applies EX/MEM forwarding to the returned operands. Detects load-use hazards and stalls fetch. Registers the decoded operands into an ID/EX pipeline register under a valid/ready handshake.

---
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage.sv | 97 +++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch / regfile / forwarding / ID-EX signal bundle for decode_stage
interface decode_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [4:0]  rf_read1_addr;
    logic [4:0]  rf_read2_addr;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic        ex_wr_is_load;
    logic [4:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_op_a;
    logic [31:0] id_op_b;
    logic [31:0] id_imm;
    logic [4:0]  id_dest;
    logic [31:0] stall_count;

    modport master (
        output if_valid, if_instr, if_pc, rf_data1, rf_data2,
               ex_wr_addr, ex_wr_data, ex_wr_is_load, mem_wr_addr, mem_wr_data,
               flush, ex_ready,
        input  if_ready, rf_read1_addr, rf_read2_addr, id_valid, id_pc, id_instr,
               id_op_a, id_op_b, id_imm, id_dest, stall_count
    );

    modport slave (
        input  if_valid, if_instr, if_pc, rf_data1, rf_data2,
               ex_wr_addr, ex_wr_data, ex_wr_is_load, mem_wr_addr, mem_wr_data,
               flush, ex_ready,
        output if_ready, rf_read1_addr, rf_read2_addr, id_valid, id_pc, id_instr,
               id_op_a, id_op_b, id_imm, id_dest, stall_count
    );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode: EX/MEM forwarding, load-use stall, ID/EX register
module decode_stage (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hazard;
    logic        ready;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] imm_q;
    logic [4:0]  dest_q;
    logic [31:0] stall_q;

    // A load in EX has no data yet, so it must not win the EX match; MEM or regfile supplies it.
    function automatic logic [31:0] forward(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic [4:0]  ex_addr,
        input logic [31:0] ex_data,
        input logic        ex_load,
        input logic [4:0]  mem_addr,
        input logic [31:0] mem_data
    );
        if (src == 5'd0)
            return 32'd0;
        else if (src == ex_addr && !ex_load)
            return ex_data;
        else if (src == mem_addr)
            return mem_data;
        else
            return rf_val;
    endfunction

    assign rs = bus.if_instr[25:21];
    assign rt = bus.if_instr[20:16];

    assign op_a = forward(rs, bus.rf_data1, bus.ex_wr_addr, bus.ex_wr_data,
                          bus.ex_wr_is_load, bus.mem_wr_addr, bus.mem_wr_data);
    assign op_b = forward(rt, bus.rf_data2, bus.ex_wr_addr, bus.ex_wr_data,
                          bus.ex_wr_is_load, bus.mem_wr_addr, bus.mem_wr_data);

    // rt is always treated as a source, so immediate-format words may stall needlessly.
    assign hazard = bus.ex_wr_is_load && (bus.ex_wr_addr != 5'd0) &&
                    (bus.ex_wr_addr == rs || bus.ex_wr_addr == rt);
    assign ready  = !bus.flush && !hazard && (!valid_q || bus.ex_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            op_a_q  <= 32'd0;
            op_b_q  <= 32'd0;
            imm_q   <= 32'd0;
            dest_q  <= 5'd0;
            stall_q <= 32'd0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (bus.if_valid && ready) begin
                valid_q <= 1'b1;
                pc_q    <= bus.if_pc;
                instr_q <= bus.if_instr;
                op_a_q  <= op_a;
                op_b_q  <= op_b;
                imm_q   <= {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};
                dest_q  <= (bus.if_instr[31:26] == 6'd0) ? bus.if_instr[15:11] : rt;
            end else if (bus.ex_ready) begin
                valid_q <= 1'b0;
            end

            if (bus.if_valid && hazard && !bus.flush && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign bus.if_ready      = ready;
    assign bus.rf_read1_addr = rs;
    assign bus.rf_read2_addr = rt;
    assign bus.id_valid      = valid_q;
    assign bus.id_pc         = pc_q;
    assign bus.id_instr      = instr_q;
    assign bus.id_op_a       = op_a_q;
    assign bus.id_op_b       = op_b_q;
    assign bus.id_imm        = imm_q;
    assign bus.id_dest       = dest_q;
    assign bus.stall_count   = stall_q;
endmodule
